// File: rtl/mioc_dram_seq.sv
// DRAM RAS/MUX/CAS sequencer with bank-map register; optional auto refresh under MIOC_AUTO_REFRESH_EN.
// Latency: RAS_N to CAS_N = T_RAS_MUX + T_MUX_CAS edges; RAS_N high >= T_PRE between accesses.
// Backpressure: WAIT_N low while a request waits out precharge or a refresh.
module mioc_dram_seq #(
    parameter int NUM_BANKS   = 2,
    parameter int T_RAS_MUX   = 1,
    parameter int T_MUX_CAS   = 1,
    parameter int T_PRE       = 2,
    parameter int T_RFSH      = 2,
    parameter int RFSH_PERIOD = 64
) (
    input  logic                 B_PHI,
    input  logic                 RST,
    input  logic                 BMREQ_N,
    input  logic                 BRD_N,
    input  logic                 N_BWR,
    input  logic                 BRFSH_N,
    input  logic                 IORQ_N,
    input  logic                 BA_HI,
    input  logic [1:0]           BA_IO,
    input  logic [3:0]           BD,
    input  logic                 BUSAK_N,
    output logic                 RAS_N,
    output logic                 MUX,
    output logic [NUM_BANKS-1:0] CAS_N,
    output logic                 WAIT_N,
    output logic [3:0]           MAP,
    output logic [6:0]           RFSH_ROW
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RAS  = 3'd1;
    localparam logic [2:0] S_COLW = 3'd2;
    localparam logic [2:0] S_ACT  = 3'd3;
    localparam logic [2:0] S_RFSH = 3'd4;
    localparam logic [2:0] S_PRE  = 3'd5;

    localparam int T_MAX_A = (T_RAS_MUX > T_MUX_CAS) ? T_RAS_MUX : T_MUX_CAS;
    localparam int T_MAX_B = (T_PRE > T_RFSH) ? T_PRE : T_RFSH;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CW      = $clog2(T_MAX + 1);

    if (NUM_BANKS < 1 || NUM_BANKS > 4) begin : g_chk_banks
        $error("NUM_BANKS must be 1..4");
    end
    if (T_RAS_MUX < 1 || T_MUX_CAS < 1 || T_PRE < 1 || T_RFSH < 1) begin : g_chk_timing
        $error("timing parameters must be >= 1");
    end
    if (RFSH_PERIOD < 1) begin : g_chk_period
        $error("RFSH_PERIOD must be >= 1");
    end

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ras_n_q, ras_n_d;
    logic                 mux_q, mux_d;
    logic [NUM_BANKS-1:0] cas_n_q, cas_n_d;
    logic [3:0]           map_q, map_d;
    logic [1:0]           code_q, code_d;

    logic map_wr, acc_go, z80_go, auto_go;
    logic ras_done, colw_done, rfsh_done, pre_done;
    logic [1:0] sel_code;

    assign map_wr    = !IORQ_N && !N_BWR && (BA_IO == 2'b01);
    assign z80_go    = !BMREQ_N && !BRFSH_N;
    assign acc_go    = !BMREQ_N && BRFSH_N && (!BRD_N || !N_BWR);
    assign sel_code  = BA_HI ? map_q[3:2] : map_q[1:0];
    assign ras_done  = cnt_q >= CW'(T_RAS_MUX - 1);
    assign colw_done = cnt_q >= CW'(T_MUX_CAS - 1);
    assign rfsh_done = cnt_q >= CW'(T_RFSH - 1);
    assign pre_done  = cnt_q >= CW'(T_PRE - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        ras_n_d = ras_n_q;
        mux_d   = mux_q;
        cas_n_d = cas_n_q;
        code_d  = code_q;
        map_d   = map_wr ? BD : map_q;
        case (state_q)
            S_IDLE: begin
                if (z80_go || auto_go) begin
                    state_d = S_RFSH;
                    ras_n_d = 1'b0;
                    cnt_d   = '0;
                end else if (acc_go) begin
                    state_d = S_RAS;
                    ras_n_d = 1'b0;
                    cnt_d   = '0;
                    code_d  = sel_code;
                end
            end
            S_RAS, S_COLW, S_ACT: begin
                // Releasing the bus request ends the cycle from any strobe phase.
                if (BMREQ_N) begin
                    state_d = S_PRE;
                    ras_n_d = 1'b1;
                    mux_d   = 1'b0;
                    cas_n_d = '1;
                    cnt_d   = '0;
                end else if (state_q == S_RAS && ras_done) begin
                    state_d = S_COLW;
                    mux_d   = 1'b1;
                    cnt_d   = '0;
                end else if (state_q == S_COLW && colw_done) begin
                    state_d = S_ACT;
                    for (int b = 0; b < NUM_BANKS; b++) cas_n_d[b] = (code_q != 2'(b));
                end
            end
            S_RFSH: begin
                if (rfsh_done) begin
                    state_d = S_PRE;
                    ras_n_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (pre_done) begin
                    cnt_d = '0;
                    if (z80_go) begin
                        state_d = S_RFSH;
                        ras_n_d = 1'b0;
                    end else if (acc_go) begin
                        state_d = S_RAS;
                        ras_n_d = 1'b0;
                        code_d  = sel_code;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge B_PHI) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ras_n_q <= 1'b1;
            mux_q   <= 1'b0;
            cas_n_q <= '1;
            map_q   <= 4'h0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ras_n_q <= ras_n_d;
            mux_q   <= mux_d;
            cas_n_q <= cas_n_d;
            map_q   <= map_d;
            code_q  <= code_d;
        end
    end

`ifdef MIOC_AUTO_REFRESH_EN
    localparam int PW = $clog2(RFSH_PERIOD + 1);

    logic [PW-1:0] per_q, per_d;
    logic          pend_q, pend_d;
    logic          auto_q, auto_d;
    logic [6:0]    row_q, row_d;
    logic          per_exp, auto_start, z80_start;

    assign per_exp    = per_q >= PW'(RFSH_PERIOD - 1);
    assign auto_go    = pend_q && !BUSAK_N;
    assign auto_start = auto_go && !z80_go && (state_q == S_IDLE);
    assign z80_start  = z80_go && ((state_q == S_IDLE) || (state_q == S_PRE && pre_done));

    always_comb begin
        per_d  = per_exp ? '0 : per_q + 1'b1;
        pend_d = pend_q || per_exp;
        auto_d = auto_q;
        row_d  = row_q;
        if (auto_start) begin
            pend_d = 1'b0;
            auto_d = 1'b1;
        end
        if (z80_start) begin
            pend_d = 1'b0;
            per_d  = '0;
        end
        // Row advances only once its own refresh has finished.
        if (state_q == S_RFSH && rfsh_done) begin
            auto_d = 1'b0;
            if (auto_q) row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge B_PHI) begin
        if (RST) begin
            per_q  <= '0;
            pend_q <= 1'b0;
            auto_q <= 1'b0;
            row_q  <= 7'd0;
        end else begin
            per_q  <= per_d;
            pend_q <= pend_d;
            auto_q <= auto_d;
            row_q  <= row_d;
        end
    end

    assign RFSH_ROW = row_q;
`else
    logic unused_busak;
    assign unused_busak = BUSAK_N;
    assign auto_go      = 1'b0;
    assign RFSH_ROW     = 7'd0;
`endif

    assign RAS_N  = ras_n_q;
    assign MUX    = mux_q;
    assign CAS_N  = cas_n_q;
    assign MAP    = map_q;
    assign WAIT_N = !(!BMREQ_N && (state_q == S_PRE || state_q == S_RFSH));
endmodule

// File: tb/tb_mioc_dram_seq.sv
// Directed bench for mioc_dram_seq (NUM_BANKS=2, default timing); strobes viewed as {RAS_N,MUX,CAS_N,WAIT_N}.
module tb_mioc_dram_seq;
`ifdef MIOC_AUTO_REFRESH_EN
    localparam int RP = 8;
`else
    localparam int RP = 64;
`endif

    logic       B_PHI = 1'b0;
    logic       RST, BMREQ_N, BRD_N, N_BWR, BRFSH_N, IORQ_N, BA_HI, BUSAK_N;
    logic [1:0] BA_IO;
    logic [3:0] BD;
    logic       RAS_N, MUX, WAIT_N;
    logic [1:0] CAS_N;
    logic [3:0] MAP;
    logic [6:0] RFSH_ROW;
    logic [4:0] strb;

    int tests_run    = 0;
    int tests_failed = 0;

    mioc_dram_seq #(.NUM_BANKS(2), .T_RAS_MUX(1), .T_MUX_CAS(1), .T_PRE(2), .T_RFSH(2),
                    .RFSH_PERIOD(RP)) dut (
        .B_PHI(B_PHI), .RST(RST), .BMREQ_N(BMREQ_N), .BRD_N(BRD_N), .N_BWR(N_BWR),
        .BRFSH_N(BRFSH_N), .IORQ_N(IORQ_N), .BA_HI(BA_HI), .BA_IO(BA_IO), .BD(BD),
        .BUSAK_N(BUSAK_N), .RAS_N(RAS_N), .MUX(MUX), .CAS_N(CAS_N), .WAIT_N(WAIT_N),
        .MAP(MAP), .RFSH_ROW(RFSH_ROW)
    );

    assign strb = {RAS_N, MUX, CAS_N, WAIT_N};

    always #5 B_PHI = ~B_PHI;

    task automatic tick;
        @(posedge B_PHI);
        #1;
    endtask

    task automatic idle_inputs;
        BMREQ_N = 1'b1; BRD_N = 1'b1; N_BWR = 1'b1; BRFSH_N = 1'b1; IORQ_N = 1'b1;
        BA_HI = 1'b0; BA_IO = 2'b00; BD = 4'h0; BUSAK_N = 1'b1;
    endtask

    task automatic map_write(input logic [3:0] v);
        IORQ_N = 1'b0; N_BWR = 1'b0; BA_IO = 2'b01; BD = v;
        tick();
        IORQ_N = 1'b1; N_BWR = 1'b1; BA_IO = 2'b00; BD = 4'h0;
    endtask

    task automatic test_reset;
        idle_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tests_run++; if (strb !== 5'b1_0_11_1) begin tests_failed++; $display("FAIL reset_strobes: got %b want 10111", strb); end
        tests_run++; if (MAP !== 4'h0) begin tests_failed++; $display("FAIL reset_map: got %h want 0", MAP); end
        tests_run++; if (RFSH_ROW !== 7'd0) begin tests_failed++; $display("FAIL reset_row: got %0d want 0", RFSH_ROW); end
    endtask

    // MAP=0100 with BA_HI=1 selects code 1, so CAS_N[1] drops.
    task automatic test_read;
        map_write(4'b0100);
        tests_run++; if (MAP !== 4'b0100) begin tests_failed++; $display("FAIL read_map: got %b want 0100", MAP); end
        BMREQ_N = 1'b0; BRD_N = 1'b0; BA_HI = 1'b1;
        tick();
        tests_run++; if (strb !== 5'b0_0_11_1) begin tests_failed++; $display("FAIL read_e0: got %b want 00111", strb); end
        tick();
        tests_run++; if (strb !== 5'b0_1_11_1) begin tests_failed++; $display("FAIL read_e1: got %b want 01111", strb); end
        tick();
        tests_run++; if (strb !== 5'b0_1_01_1) begin tests_failed++; $display("FAIL read_e2: got %b want 01011", strb); end
        tick(); tick();
        tests_run++; if (strb !== 5'b0_1_01_1) begin tests_failed++; $display("FAIL read_hold: got %b want 01011", strb); end
        BMREQ_N = 1'b1; BRD_N = 1'b1; BA_HI = 1'b0;
        tick();
        tests_run++; if (strb !== 5'b1_0_11_1) begin tests_failed++; $display("FAIL read_release: got %b want 10111", strb); end
        tick(); tick();
    endtask

    task automatic test_map_unmapped;
        map_write(4'hB);
        tests_run++; if (MAP !== 4'hB) begin tests_failed++; $display("FAIL map_write: got %h want b", MAP); end
        IORQ_N = 1'b0; N_BWR = 1'b0; BA_IO = 2'b10; BD = 4'h5;
        tick();
        idle_inputs();
        tests_run++; if (MAP !== 4'hB) begin tests_failed++; $display("FAIL map_wrong_port: got %h want b", MAP); end
        BMREQ_N = 1'b0; N_BWR = 1'b0; BA_HI = 1'b1;
        tick();
        tests_run++; if (strb !== 5'b0_0_11_1) begin tests_failed++; $display("FAIL unmap_e0: got %b want 00111", strb); end
        tick();
        tests_run++; if (strb !== 5'b0_1_11_1) begin tests_failed++; $display("FAIL unmap_e1: got %b want 01111", strb); end
        tick(); tick();
        tests_run++; if (strb !== 5'b0_1_11_1) begin tests_failed++; $display("FAIL unmap_no_cas: got %b want 01111", strb); end
        tests_run++; if (MAP !== 4'hB) begin tests_failed++; $display("FAIL unmap_map_kept: got %h want b", MAP); end
        idle_inputs();
        tick();
        tests_run++; if (strb !== 5'b1_0_11_1) begin tests_failed++; $display("FAIL unmap_release: got %b want 10111", strb); end
        tick(); tick();
    endtask

    task automatic test_back_to_back;
        map_write(4'h4);
        BMREQ_N = 1'b0; BRD_N = 1'b0; BA_HI = 1'b0;
        tick(); tick(); tick();
        tests_run++; if (strb !== 5'b0_1_10_1) begin tests_failed++; $display("FAIL b2b_cas0: got %b want 01101", strb); end
        BMREQ_N = 1'b1;
        tick();
        tests_run++; if (strb !== 5'b1_0_11_1) begin tests_failed++; $display("FAIL b2b_release: got %b want 10111", strb); end
        BMREQ_N = 1'b0;
        #1;
        tests_run++; if (strb !== 5'b1_0_11_0) begin tests_failed++; $display("FAIL b2b_wait1: got %b want 10110", strb); end
        tick();
        tests_run++; if (strb !== 5'b1_0_11_0) begin tests_failed++; $display("FAIL b2b_wait2: got %b want 10110", strb); end
        tick();
        tests_run++; if (strb !== 5'b0_0_11_1) begin tests_failed++; $display("FAIL b2b_new_ras: got %b want 00111", strb); end
        tick(); tick();
        tests_run++; if (strb !== 5'b0_1_10_1) begin tests_failed++; $display("FAIL b2b_cas1: got %b want 01101", strb); end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_refresh_priority;
        BMREQ_N = 1'b0; BRFSH_N = 1'b0; BRD_N = 1'b0;
        tick();
        tests_run++; if (strb !== 5'b0_0_11_0) begin tests_failed++; $display("FAIL rfsh_e0: got %b want 00110", strb); end
        idle_inputs();
        tick();
        tests_run++; if (strb !== 5'b0_0_11_1) begin tests_failed++; $display("FAIL rfsh_e1: got %b want 00111", strb); end
        tick();
        tests_run++; if (strb !== 5'b1_0_11_1) begin tests_failed++; $display("FAIL rfsh_end: got %b want 10111", strb); end
        BMREQ_N = 1'b0; BRD_N = 1'b0;
        #1;
        tests_run++; if (WAIT_N !== 1'b0) begin tests_failed++; $display("FAIL rfsh_pre_wait: got %b want 0", WAIT_N); end
        tick();
        tests_run++; if (strb !== 5'b1_0_11_0) begin tests_failed++; $display("FAIL rfsh_pre2: got %b want 10110", strb); end
        tick();
        tests_run++; if (strb !== 5'b0_0_11_1) begin tests_failed++; $display("FAIL rfsh_next_ras: got %b want 00111", strb); end
        BMREQ_N = 1'b1; BRD_N = 1'b1;
        tick();
        tests_run++; if (strb !== 5'b1_0_11_1) begin tests_failed++; $display("FAIL abort_in_ras: got %b want 10111", strb); end
        tick(); tick();
    endtask

    task automatic test_reset_mid_act;
        map_write(4'h4);
        BMREQ_N = 1'b0; BRD_N = 1'b0; BA_HI = 1'b0;
        tick(); tick(); tick(); tick();
        tests_run++; if (strb !== 5'b0_1_10_1) begin tests_failed++; $display("FAIL mid_act: got %b want 01101", strb); end
        RST = 1'b1; BMREQ_N = 1'b1; BRD_N = 1'b1;
        tick();
        RST = 1'b0;
        tests_run++; if (strb !== 5'b1_0_11_1) begin tests_failed++; $display("FAIL mid_reset_strobes: got %b want 10111", strb); end
        tests_run++; if (MAP !== 4'h0) begin tests_failed++; $display("FAIL mid_reset_map: got %h want 0", MAP); end
        BMREQ_N = 1'b0; BRD_N = 1'b0;
        tick();
        tests_run++; if (strb !== 5'b0_0_11_1) begin tests_failed++; $display("FAIL post_reset_ras: got %b want 00111", strb); end
        idle_inputs();
        tick(); tick(); tick();
    endtask

`ifdef MIOC_AUTO_REFRESH_EN
    task automatic test_auto_refresh;
        int   falls     = 0;
        int   last_edge = 0;
        logic prev;
        idle_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        BUSAK_N = 1'b0;
        prev = RAS_N;
        for (int i = 1; i <= RP * 132; i++) begin
            tick();
            if (prev && !RAS_N) begin
                tests_run++;
                if (RFSH_ROW !== 7'(falls % 128)) begin
                    tests_failed++; $display("FAIL auto_row: got %0d want %0d", RFSH_ROW, falls % 128);
                end
                if (falls > 0) begin
                    tests_run++;
                    if (i - last_edge != RP) begin
                        tests_failed++; $display("FAIL auto_period: got %0d want %0d", i - last_edge, RP);
                    end
                end
                last_edge = i;
                falls++;
            end
            prev = RAS_N;
        end
        tests_run++; if (falls < 130) begin tests_failed++; $display("FAIL auto_count: got %0d want >=130", falls); end
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        RST = 1'b1;
        test_reset();
        test_read();
        test_map_unmapped();
        test_back_to_back();
        test_refresh_priority();
        tests_run++; if (RFSH_ROW !== 7'd0) begin tests_failed++; $display("FAIL row_after_rfsh: got %0d want 0", RFSH_ROW); end
        test_reset_mid_act();
`ifdef MIOC_AUTO_REFRESH_EN
        test_auto_refresh();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
